// File: rtl/hamming_secded_dec.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control and
// saturating single/double error counters.
module hamming_secded_dec #(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W+PAR_W:0]    code_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     err_sgl,
    output logic                     err_dbl,
    output logic [PAR_W-1:0]         err_pos,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         cnt_sgl,
    output logic [CNT_W-1:0]         cnt_dbl
);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    function automatic logic [PAR_W-1:0] calc_syn(input logic [CODE_W-1:0] cw);
        logic [PAR_W-1:0]  s;
        logic [CODE_W-1:0] t;
        s = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int pos = 1; pos < CODE_W; pos++) begin
                t = cw >> (pos - 1);
                if (((pos >> k) & 1) == 1 && t[0])
                    s = s ^ (PAR_W'(1) << k);
            end
        end
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] flip_pos(input logic [CODE_W-1:0] cw,
                                                   input logic [PAR_W-1:0]  s);
        logic [CODE_W-1:0] r;
        r = cw;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if (int'(s) == pos)
                r = r ^ (CODE_W'(1) << (pos - 1));
        end
        return r;
    endfunction

    // Non-power-of-two positions carry payload, lowest position first.
    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        logic [CODE_W-1:0] t;
        int                j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0 && j < DATA_W) begin
                t = cw >> (pos - 1);
                d = d | (DATA_W'(t[0]) << j);
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                run;
    logic                vld_p1, vld_p2;
    logic                load_p1, adv_p2;
    logic [CODE_W-1:0]   code_p1;
    logic [PAR_W-1:0]    syn_p1;
    logic                par_p1;
    logic [CODE_W-1:0]   fix_c;
    logic                sgl_c, dbl_c;
    logic [PAR_W-1:0]    pos_c;
    logic [DATA_W-1:0]   data_p2;
    logic                sgl_p2, dbl_p2;
    logic [PAR_W-1:0]    pos_p2;

    assign adv_p2   = vld_p1 & (~vld_p2 | out_ready);
    assign in_ready = run & (~vld_p1 | adv_p2);
    assign load_p1  = in_valid & in_ready;

    // run keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            run <= 1'b1;
            if (load_p1)
                vld_p1 <= 1'b1;
            else if (adv_p2)
                vld_p1 <= 1'b0;
            if (adv_p2)
                vld_p2 <= 1'b1;
            else if (out_ready)
                vld_p2 <= 1'b0;
        end
    end

    // Stage 1: capture codeword, syndrome and overall parity
    always_ff @(posedge clk) begin
        if (load_p1) begin
            code_p1 <= code_in;
            syn_p1  <= calc_syn(code_in);
            par_p1  <= ^code_in;
        end
    end

    always_comb begin
        fix_c = code_p1;
        sgl_c = 1'b0;
        dbl_c = 1'b0;
        pos_c = '0;
        if (par_p1) begin
            if (syn_p1 == '0) begin
                sgl_c = 1'b1;
            end else if (int'(syn_p1) <= CODE_W - 1) begin
                sgl_c = 1'b1;
                pos_c = syn_p1;
                fix_c = flip_pos(code_p1, syn_p1);
            end else begin
                dbl_c = 1'b1;
            end
        end else if (syn_p1 != '0) begin
            dbl_c = 1'b1;
        end
    end

    // Stage 2: corrected payload and classification flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            sgl_p2  <= 1'b0;
            dbl_p2  <= 1'b0;
            pos_p2  <= '0;
        end else if (adv_p2) begin
            data_p2 <= extract(fix_c);
            sgl_p2  <= sgl_c;
            dbl_p2  <= dbl_c;
            pos_p2  <= pos_c;
        end
    end

    assign out_valid = vld_p2;
    assign data_out  = data_p2;
    assign err_sgl   = sgl_p2;
    assign err_dbl   = dbl_p2;
    assign err_pos   = pos_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sgl <= '0;
            cnt_dbl <= '0;
        end else if (clr_cnt) begin
            cnt_sgl <= '0;
            cnt_dbl <= '0;
        end else if (vld_p2 && out_ready) begin
            if (sgl_p2)
                cnt_sgl <= sat_inc(cnt_sgl);
            if (dbl_p2)
                cnt_dbl <= sat_inc(cnt_dbl);
        end
    end
endmodule

// File: tb/tb_hamming_secded_dec.sv
// Randomized bench for hamming_secded_dec: a behavioural SECDED model feeds a
// scoreboard; a second instance with narrow counters exercises saturation.
module tb_hamming_secded_dec;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = DW + PW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sgl;
        logic          dbl;
        logic [PW-1:0] pos;
    } exp_t;

    logic          clk, rst_n, in_valid, out_ready, clr_cnt;
    logic [CW-1:0] code_in;
    logic          in_ready, out_valid, err_sgl, err_dbl;
    logic [DW-1:0] data_out;
    logic [PW-1:0] err_pos;
    logic [15:0]   cnt_sgl, cnt_dbl;
    logic          s_in_ready, s_out_valid, s_err_sgl, s_err_dbl;
    logic [DW-1:0] s_data_out;
    logic [PW-1:0] s_err_pos;
    logic [3:0]    s_cnt_sgl, s_cnt_dbl;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    exp_t exp_q[$];
    int   m_sgl, m_dbl, m4_sgl, m4_dbl;
    logic rnd_on = 1'b0;

    hamming_secded_dec #(.DATA_W(DW), .PAR_W(PW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_sgl(err_sgl), .err_dbl(err_dbl),
        .err_pos(err_pos), .clr_cnt(clr_cnt), .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl)
    );

    hamming_secded_dec #(.DATA_W(DW), .PAR_W(PW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .code_in(code_in), .out_valid(s_out_valid), .out_ready(out_ready),
        .data_out(s_data_out), .err_sgl(s_err_sgl), .err_dbl(s_err_dbl),
        .err_pos(s_err_pos), .clr_cnt(clr_cnt), .cnt_sgl(s_cnt_sgl), .cnt_dbl(s_cnt_dbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: syndrome is the XOR of the indices of all set bits.
    function automatic exp_t ref_decode(input logic [CW-1:0] cw);
        exp_t          e;
        int            s, j;
        logic [CW-1:0] c;
        e = '0;
        c = cw;
        s = 0;
        for (int pos = 1; pos < CW; pos++)
            if (cw[pos-1]) s = s ^ pos;
        if ($countones(cw) % 2 == 1) begin
            if (s == 0) begin
                e.sgl = 1'b1;
            end else if (s <= CW - 1) begin
                e.sgl = 1'b1;
                e.pos = s[PW-1:0];
                c[s-1] = ~c[s-1];
            end else begin
                e.dbl = 1'b1;
            end
        end else if (s != 0) begin
            e.dbl = 1'b1;
        end
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ($countones(pos) != 1) begin
                e.data[j] = c[pos-1];
                j++;
            end
        end
        return e;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int            j, s;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ($countones(pos) != 1) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        s = 0;
        for (int pos = 1; pos < CW; pos++)
            if (c[pos-1]) s = s ^ pos;
        for (int k = 0; k < PW; k++)
            c[(1 << k) - 1] = s[k];
        c[CW-1] = ^c[CW-2:0];
        return c;
    endfunction

    function automatic logic [CW-1:0] gen_word(input int kind);
        logic [CW-1:0] c;
        int            a, b;
        c = encode(DW'($urandom));
        a = $urandom_range(0, CW - 1);
        b = (a + $urandom_range(1, CW - 1)) % CW;
        case (kind)
            1:       c[a] = ~c[a];
            2:       begin c[a] = ~c[a]; c[b] = ~c[b]; end
            3:       c = CW'($urandom);
            default: ;
        endcase
        return c;
    endfunction

    task automatic send(input logic [CW-1:0] cw, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        code_in  = cw;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard and counter model, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        hs = 1'b0;
        e  = '0;
        if (!rst_n) begin
            exp_q.delete();
            m_sgl = 0; m_dbl = 0; m4_sgl = 0; m4_dbl = 0;
        end else begin
            chk("cnt_sgl", cnt_sgl, m_sgl);
            chk("cnt_dbl", cnt_dbl, m_dbl);
            chk("sat_cnt_sgl", s_cnt_sgl, m4_sgl);
            chk("sat_cnt_dbl", s_cnt_dbl, m4_dbl);
            if (out_valid) begin
                chk("flag_excl", err_sgl & err_dbl, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("data_out", data_out, e.data);
                    chk("err_sgl", err_sgl, e.sgl);
                    chk("err_dbl", err_dbl, e.dbl);
                    chk("err_pos", err_pos, e.pos);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                        hs = 1'b1;
                    end
                end
            end
            if (clr_cnt) begin
                m_sgl = 0; m_dbl = 0; m4_sgl = 0; m4_dbl = 0;
            end else if (hs) begin
                if (e.sgl) begin
                    if (m_sgl < 65535) m_sgl++;
                    if (m4_sgl < 15)   m4_sgl++;
                end
                if (e.dbl) begin
                    if (m_dbl < 65535) m_dbl++;
                    if (m4_dbl < 15)   m4_dbl++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 99) == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int            c0, n0;
        logic [CW-1:0] w;
        rst_n = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_flags", {err_sgl, err_dbl, err_pos}, 0);
        chk("rst_cnts", {cnt_sgl, cnt_dbl}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", in_ready, 0);
        @(negedge clk);
        chk("rdy_after_edge", in_ready, 1);
        @(posedge clk); #1;

        // Clean all-ones word, with latency check
        send(13'h0F77, '{data: 8'hFF, sgl: 1'b0, dbl: 1'b0, pos: 4'd0});
        in_valid = 1'b0;
        @(negedge clk); chk("lat_cycle1", out_valid, 0);
        @(negedge clk); chk("lat_cycle2", out_valid, 1);
        idle_cycles(2);

        c0 = cnt_sgl;
        send(13'h0010, '{data: 8'h00, sgl: 1'b1, dbl: 1'b0, pos: 4'd5});
        idle_cycles(3);
        chk("cnt_sgl_inc", cnt_sgl, c0 + 1);
        c0 = cnt_dbl;
        send(13'h0003, '{data: 8'h00, sgl: 1'b0, dbl: 1'b1, pos: 4'd0});
        idle_cycles(3);
        chk("cnt_dbl_inc", cnt_dbl, c0 + 1);
        send(13'h1000, '{data: 8'h00, sgl: 1'b1, dbl: 1'b0, pos: 4'd0});
        idle_cycles(3);

        // Back-to-back burst across a 3-cycle downstream stall
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    w = gen_word($urandom_range(0, 3));
                    send(w, ref_decode(w));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle_cycles(6);
        chk("burst_delivered", n_out - n0, 8);
        chk("burst_queue_empty", exp_q.size(), 0);

        // Saturation on the narrow-counter instance
        clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
        for (int i = 0; i < 17; i++) begin
            w = gen_word(1);
            send(w, ref_decode(w));
        end
        idle_cycles(4);
        chk("sat_hold_15", s_cnt_sgl, 15);
        chk("cnt_sgl_17", cnt_sgl, 17);

        // Clear coinciding with an increment
        clr_cnt = 1'b1;
        send(13'h0010, '{data: 8'h00, sgl: 1'b1, dbl: 1'b0, pos: 4'd5});
        idle_cycles(3);
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins_main", cnt_sgl, 0);
        chk("clr_wins_sat", s_cnt_sgl, 0);
        @(posedge clk); #1;

        // Random traffic with random backpressure and clears
        rnd_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            w = gen_word($urandom_range(0, 3));
            send(w, ref_decode(w));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        in_valid = 1'b0;
        rnd_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1; clr_cnt = 1'b0;
        idle_cycles(6);
        chk("random_queue_empty", exp_q.size(), 0);

        // Error traffic, then reset with words in flight
        for (int i = 0; i < 3; i++) begin
            w = gen_word(2);
            send(w, ref_decode(w));
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_outputs", {data_out, err_sgl, err_dbl, err_pos}, 0);
        chk("midrst_cnts", {cnt_sgl, cnt_dbl}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); chk("midrst_rdy_pre", in_ready, 0);
        @(negedge clk); chk("midrst_rdy_post", in_ready, 1);
        chk("midrst_no_stale", out_valid, 0);
        @(posedge clk); #1;
        send(13'h0F77, '{data: 8'hFF, sgl: 1'b0, dbl: 1'b0, pos: 4'd0});
        idle_cycles(4);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hamming_secded_dec.md
HAMMING_SECDED_DEC -- requirements
Module: hamming_secded_dec

Interface
REQ-001 Parameter DATA_W, default 8: number of payload data bits.
REQ-002 Parameter PAR_W, default 4: number of Hamming parity bits; SHALL satisfy 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 Parameter CNT_W, default 16: width of each error-statistics counter.
REQ-004 Derived CODE_W = DATA_W+PAR_W+1: codeword width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 in_valid  in  1  codeword on code_in is valid.
REQ-008 in_ready  out  1  block accepts code_in this cycle.
REQ-009 code_in  in  CODE_W  received codeword.
REQ-010 out_valid  out  1  decoded result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 data_out  out  DATA_W  corrected payload.
REQ-013 err_sgl  out  1  single-bit error detected and corrected.
REQ-014 err_dbl  out  1  uncorrectable error detected.
REQ-015 err_pos  out  PAR_W  Hamming position corrected; 0 if none.
REQ-016 clr_cnt  in  1  synchronous clear of both counters.
REQ-017 cnt_sgl  out  CNT_W  count of err_sgl results delivered.
REQ-018 cnt_dbl  out  CNT_W  count of err_dbl results delivered.

Function
REQ-019 Codeword layout: code_in[i], i < CODE_W-1, SHALL hold Hamming position i+1; code_in[CODE_W-1] SHALL hold the overall parity bit.
REQ-020 Positions that are powers of two SHALL be parity bits; the remaining positions, ascending, SHALL map to data_out[0] upward.
REQ-021 Syndrome bit k SHALL be the XOR of all positions whose index has bit k set; p SHALL be the XOR of all CODE_W bits.
REQ-022 Classification: S=0,p=0 -> clean; p=1,S=0 -> overall-parity bit in error, err_sgl=1, err_pos=0, data unchanged; p=1, 1<=S<=CODE_W-1 -> flip position S, err_sgl=1, err_pos=S; p=1, S>CODE_W-1 -> err_dbl=1, no flip; S!=0,p=0 -> err_dbl=1, no flip, err_pos=0.
REQ-023 err_sgl and err_dbl SHALL never both be 1.
REQ-024 Two-stage pipeline: stage 1 registers the codeword and syndrome; stage 2 registers corrected data and flags; latency from input handshake to out_valid SHALL be 2 cycles when unstalled.
REQ-025 A stage SHALL load when it is empty or its contents move on in the same cycle; in_ready = !s1_valid | (s1 moves to s2).
REQ-026 Throughput SHALL be one codeword per cycle while out_ready=1; no bubbles and no loss under any out_ready pattern.
REQ-027 data_out, err_sgl, err_dbl and err_pos SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Counters SHALL increment on out_valid&out_ready with the matching flag set, and SHALL saturate at 2^CNT_W-1.
REQ-029 clr_cnt=1 SHALL zero both counters on the next edge, taking precedence over a simultaneous increment.

Reset
REQ-030 While rst_n=0: in_ready=0, out_valid=0, data_out=0, err_sgl=0, err_dbl=0, err_pos=0, cnt_sgl=0, cnt_dbl=0, both stages empty.
REQ-031 Reset mid-operation SHALL discard all in-flight codewords; in_ready SHALL rise on the first clk edge after rst_n deasserts.

Verification (DATA_W=8, PAR_W=4, CODE_W=13)
REQ-032 code_in=13'h0F77, out_ready=1 -> 2 cycles later data_out=8'hFF, err_sgl=0, err_dbl=0, err_pos=0.
REQ-033 code_in=13'h0010 (position 5 flipped from zero) -> data_out=8'h00, err_sgl=1, err_pos=5, cnt_sgl increments by 1.
REQ-034 code_in=13'h0003 (positions 1 and 2 flipped) -> err_dbl=1, err_sgl=0, err_pos=0, cnt_dbl increments by 1.
REQ-035 code_in=13'h1000 (overall parity bit flipped) -> data_out=8'h00, err_sgl=1, err_pos=0.
REQ-036 Back-to-back stream of 8 words with out_ready held 0 for 3 cycles -> in_ready drops, all 8 results delivered in order, none lost or duplicated.
REQ-037 cnt_sgl preset at 16'hFFFF plus one more single error -> stays at 16'hFFFF; clr_cnt asserted on the same cycle as an increment -> 0.
